mem_access_unit: RTL and testbench

Parametrised next-generation memory stage for the sequential RISC-V core, sitting between execute/writeback control and the data memory. Accepts one load or store per handshake, decodes RV64 access size from funct3, checks alignment, and drives a byte-enabled, variable-latency request/acknowledge data-memory port with a timeout. Returns sign- or zero-extended load data, or an error code, as a single-cycle response pulse.

---
 rtl/mem_access_unit.sv | 208 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory stage: one RV64/RV32 load or store per handshake, sized byte-enabled data-memory access.
// Latency: 2 cycles accept->resp_valid with immediate ack; 1 cycle for a rejected request; timeout after TIMEOUT cycles of dmem_req.
// Backpressure: req_ready_o is high only when idle; the response is a one-cycle pulse with no backpressure.
//
// Ports: req_* is the request from execute/writeback, resp_* is the response pulse,
// dmem_* is the req/ack data-memory port (dmem_req_o held until dmem_ack_i or timeout).
// Build option: define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned accesses with code 1;
// without it the address is rounded down to the access size and the access proceeds.
module mem_access_unit #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_read_i,
    input  logic                req_write_i,
    input  logic [2:0]          req_funct3_i,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [XLEN-1:0]     req_wdata_i,
    output logic                resp_valid_o,
    output logic [XLEN-1:0]     resp_rdata_o,
    output logic [2:0]          resp_err_code_o,
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [ADDR_W-1:0]   dmem_addr_o,
    output logic [XLEN/8-1:0]   dmem_be_o,
    output logic [XLEN-1:0]     dmem_wdata_o,
    input  logic                dmem_ack_i,
    input  logic [XLEN-1:0]     dmem_rdata_i,
    input  logic                dmem_err_i
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);
    localparam int CW  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_MISALIGN = 3'd1;
    localparam logic [2:0] ERR_ILLEGAL = 3'd2;
    localparam logic [2:0] ERR_BUS     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                dreq_q, dreq_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [NB-1:0]       be_q, be_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [2:0]          f3_q, f3_d;
    logic [OFF-1:0]      lane_q, lane_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rv_q, rv_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [2:0]          code_q, code_d;

    // Request decode, evaluated against the live request inputs while idle.
    logic [1:0]          size_log;
    logic [ADDR_W-1:0]   size_mask;
    logic [ADDR_W-1:0]   eff_addr;
    logic [OFF-1:0]      lane;
    logic [15:0]         be_wide;
    logic                illegal;

    assign size_log  = req_funct3_i[1:0];
    assign size_mask = (ADDR_W'(1) << size_log) - ADDR_W'(1);
    // Wider-than-bus sizes are illegal; RV32 has no LWU either.
    assign illegal   = (req_read_i == req_write_i) || (req_funct3_i == 3'b111) ||
                       (req_write_i && req_funct3_i[2]) || (int'(size_log) > OFF) ||
                       ((XLEN == 32) && (req_funct3_i == 3'b110));
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = |(req_addr_i & size_mask);
    assign eff_addr   = req_addr_i;
`else
    assign eff_addr   = req_addr_i & ~size_mask;
`endif
    assign lane    = eff_addr[OFF-1:0];
    assign be_wide = ((16'd1 << (5'd1 << size_log)) - 16'd1) << lane;

    // Load data: pull the addressed lane down to bit 0, then extend per funct3.
    logic [XLEN-1:0] rd_shift, ld_data;
    assign rd_shift = dmem_rdata_i >> {lane_q, 3'b000};

    always_comb begin
        ld_data = rd_shift;
        case (f3_q[1:0])
            2'd0: if (f3_q[2]) ld_data = XLEN'(rd_shift[7:0]);
                  else         ld_data = XLEN'($signed(rd_shift[7:0]));
            2'd1: if (f3_q[2]) ld_data = XLEN'(rd_shift[15:0]);
                  else         ld_data = XLEN'($signed(rd_shift[15:0]));
            2'd2: if (f3_q[2]) ld_data = XLEN'(rd_shift[31:0]);
                  else         ld_data = XLEN'($signed(rd_shift[31:0]));
            default: ld_data = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        dreq_d  = dreq_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        rv_d    = 1'b0;
        rdata_d = '0;
        code_d  = ERR_OK;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    ready_d = 1'b0;
                    if (illegal) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                        code_d  = ERR_ILLEGAL;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
                    end else if (misaligned) begin
                        state_d = RESP;
                        rv_d    = 1'b1;
                        code_d  = ERR_MISALIGN;
`endif
                    end else begin
                        state_d = ACCESS;
                        dreq_d  = 1'b1;
                        we_d    = req_write_i;
                        addr_d  = eff_addr & ~ADDR_W'(NB - 1);
                        be_d    = be_wide[NB-1:0];
                        wdata_d = req_wdata_i << {lane, 3'b000};
                        f3_d    = req_funct3_i;
                        lane_d  = lane;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack_i) begin
                    state_d = RESP;
                    dreq_d  = 1'b0;
                    rv_d    = 1'b1;
                    if (dmem_err_i) code_d = ERR_BUS;
                    else if (!we_q) rdata_d = ld_data;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Last cycle of the wait window: dmem_req has been up TIMEOUT cycles.
                    state_d = RESP;
                    dreq_d  = 1'b0;
                    rv_d    = 1'b1;
                    code_d  = ERR_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            dreq_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            rdata_q <= '0;
            code_q  <= ERR_OK;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            dreq_q  <= dreq_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            code_q  <= code_d;
        end
    end

    assign req_ready_o     = ready_q;
    assign dmem_req_o      = dreq_q;
    assign dmem_we_o       = we_q;
    assign dmem_addr_o     = addr_q;
    assign dmem_be_o       = be_q;
    assign dmem_wdata_o    = wdata_q;
    assign resp_valid_o    = rv_q;
    assign resp_rdata_o    = rdata_q;
    assign resp_err_code_o = code_q;
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int TO = 4;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 64-bit instance
    logic        req_valid = 0, req_read = 0, req_write = 0;
    logic [2:0]  req_funct3 = 0;
    logic [63:0] req_addr = 0, req_wdata = 0;
    logic        req_ready, resp_valid, dmem_req, dmem_we;
    logic [63:0] resp_rdata, dmem_addr, dmem_wdata;
    logic [2:0]  resp_code;
    logic [7:0]  dmem_be;
    logic        dmem_ack = 0, dmem_err = 0;
    logic [63:0] dmem_rdata = 0;

    mem_access_unit #(.XLEN(64), .ADDR_W(64), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_read_i(req_read), .req_write_i(req_write), .req_funct3_i(req_funct3),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_code_o(resp_code),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_addr_o(dmem_addr),
        .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
        .dmem_ack_i(dmem_ack), .dmem_rdata_i(dmem_rdata), .dmem_err_i(dmem_err));

    // 32-bit instance, used only for size legality
    logic        v32 = 0, rd32 = 0;
    logic [2:0]  f3_32 = 0;
    logic [31:0] a32 = 0;
    logic        rdy32, rv32, dreq32, we32;
    logic [31:0] rdat32, daddr32, dwd32;
    logic [2:0]  code32;
    logic [3:0]  be32;

    mem_access_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(v32), .req_ready_o(rdy32),
        .req_read_i(rd32), .req_write_i(1'b0), .req_funct3_i(f3_32),
        .req_addr_i(a32), .req_wdata_i(32'd0),
        .resp_valid_o(rv32), .resp_rdata_o(rdat32), .resp_err_code_o(code32),
        .dmem_req_o(dreq32), .dmem_we_o(we32), .dmem_addr_o(daddr32),
        .dmem_be_o(be32), .dmem_wdata_o(dwd32),
        .dmem_ack_i(1'b0), .dmem_rdata_i(32'd0), .dmem_err_i(1'b0));

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-level expectations, updated by the stimulus just after each rising edge.
    logic        run_chk = 0;
    logic        exp_ready = 1, exp_req = 0, exp_rv = 0, exp_we = 0;
    logic [2:0]  exp_code = 0;
    logic [63:0] exp_rdata = 0, exp_addr = 0, exp_wdata = 0;
    logic [7:0]  exp_be = 0;

    // Observed DUT activity per transaction, for the hand-computed literal checks.
    int          req_cnt = 0, resp_cnt = 0;
    logic [63:0] cap_rdata = 0, cap_addr = 0;
    logic [2:0]  cap_code = 0;
    logic [7:0]  cap_be = 0;

    always @(negedge clk) begin
        if (run_chk) begin
            chk("req_ready", {63'd0, req_ready}, {63'd0, exp_ready});
            chk("dmem_req", {63'd0, dmem_req}, {63'd0, exp_req});
            chk("resp_valid", {63'd0, resp_valid}, {63'd0, exp_rv});
            chk("resp_err_code", {61'd0, resp_code}, {61'd0, exp_code});
            chk("resp_rdata", resp_rdata, exp_rdata);
            if (exp_req) begin
                chk("dmem_addr", dmem_addr, exp_addr);
                chk("dmem_be", {56'd0, dmem_be}, {56'd0, exp_be});
                chk("dmem_we", {63'd0, dmem_we}, {63'd0, exp_we});
                chk("dmem_wdata", dmem_wdata, exp_wdata);
            end
            if (dmem_req === 1'b1) begin
                req_cnt++;
                cap_be   = dmem_be;
                cap_addr = dmem_addr;
            end
            if (resp_valid === 1'b1) begin
                resp_cnt++;
                cap_rdata = resp_rdata;
                cap_code  = resp_code;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction; w = wait cycles before ack, negative = never ack.
    task automatic txn(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input int w, input logic [63:0] rdata, input logic err);
        int          size, lane;
        logic [63:0] eaddr, m, v;
        logic [15:0] bw;
        logic [2:0]  code;
        logic        illegal, misal;
        size    = 1 << f3[1:0];
        illegal = (rd == wr) || (f3 == 3'b111) || (wr && f3[2]);
        misal   = (addr % size) != 0;
        eaddr   = CHK_EN ? addr : addr - (addr % size);
        code    = illegal ? 3'd2 : ((CHK_EN && misal) ? 3'd1 : 3'd0);
        lane    = int'(eaddr % 8);
        bw      = ((16'd1 << size) - 16'd1) << lane;
        m       = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
        v       = (rdata >> (8 * lane)) & m;
        if (!f3[2] && v[8*size-1]) v = v | ~m;

        req_cnt = 0;
        resp_cnt = 0;
        req_valid = 1; req_read = rd; req_write = wr; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 0; req_read = 0; req_write = 0;
        exp_ready = 0;
        if (code != 3'd0) begin
            exp_rv = 1; exp_code = code; exp_rdata = 0;
            step();
        end else begin
            exp_req = 1; exp_addr = eaddr & ~64'h7; exp_be = bw[7:0];
            exp_we = wr; exp_wdata = wdata << (8 * lane);
            if (w >= 0) begin
                repeat (w) step();
                dmem_ack = 1; dmem_rdata = rdata; dmem_err = err;
                step();
                dmem_ack = 0; dmem_rdata = 0; dmem_err = 0;
                exp_code  = err ? 3'd3 : 3'd0;
                exp_rdata = (err || wr) ? 64'd0 : v;
            end else begin
                repeat (TO) step();
                exp_code = 3'd4; exp_rdata = 0;
            end
            exp_req = 0; exp_rv = 1;
            step();
        end
        exp_rv = 0; exp_code = 0; exp_rdata = 0; exp_ready = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) step();
        run_chk = 1;
        chk("rst_dmem_addr", dmem_addr, 64'd0);
        chk("rst_dmem_be", {56'd0, dmem_be}, 64'd0);
        chk("rst_dmem_wdata", dmem_wdata, 64'd0);
        chk("rst_dmem_we", {63'd0, dmem_we}, 64'd0);
        rst_n = 1;
        step();

        // SD, ack after 3 wait cycles
        txn(0, 1, 3'b011, 64'h100, 64'h1122334455667788, 3, 64'd0, 0);
        chk("sd_be", {56'd0, cap_be}, 64'hFF);
        chk("sd_addr", cap_addr, 64'h100);
        chk("sd_req_cycles", 64'(req_cnt), 64'd4);
        chk("sd_resp_count", 64'(resp_cnt), 64'd1);
        chk("sd_code", {61'd0, cap_code}, 64'd0);

        // LB / LBU from 0x103
        txn(1, 0, 3'b000, 64'h103, 64'd0, 0, 64'h0000000080000000, 0);
        chk("lb_be", {56'd0, cap_be}, 64'h08);
        chk("lb_rdata", cap_rdata, 64'hFFFFFFFFFFFFFF80);
        txn(1, 0, 3'b100, 64'h103, 64'd0, 1, 64'h0000000080000000, 0);
        chk("lbu_rdata", cap_rdata, 64'h80);

        // LW at 0x102: rejected or rounded down depending on build
        txn(1, 0, 3'b010, 64'h102, 64'd0, 0, 64'h0000000012345678, 0);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        chk("lw_mis_code", {61'd0, cap_code}, 64'd1);
        chk("lw_mis_req_cycles", 64'(req_cnt), 64'd0);
`else
        chk("lw_round_addr", cap_addr, 64'h100);
        chk("lw_round_be", {56'd0, cap_be}, 64'h0F);
        chk("lw_round_rdata", cap_rdata, 64'h12345678);
`endif

        // Timeout, then a stray ack while idle
        txn(1, 0, 3'b011, 64'h200, 64'd0, -1, 64'd0, 0);
        chk("to_req_cycles", 64'(req_cnt), 64'd4);
        chk("to_code", {61'd0, cap_code}, 64'd4);
        resp_cnt = 0;
        dmem_ack = 1; dmem_rdata = 64'hDEAD;
        step();
        dmem_ack = 0; dmem_rdata = 0;
        repeat (2) step();
        chk("stray_ack_resp", 64'(resp_cnt), 64'd0);

        // Bus error
        txn(1, 0, 3'b001, 64'h106, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        chk("buserr_code", {61'd0, cap_code}, 64'd3);
        chk("buserr_rdata", cap_rdata, 64'd0);

        // Illegal requests
        txn(1, 1, 3'b010, 64'h100, 64'd0, 0, 64'd0, 0);
        chk("rw_both_code", {61'd0, cap_code}, 64'd2);
        chk("rw_both_req_cycles", 64'(req_cnt), 64'd0);
        txn(0, 0, 3'b000, 64'h100, 64'd0, 0, 64'd0, 0);
        txn(1, 0, 3'b111, 64'h100, 64'd0, 0, 64'd0, 0);
        txn(0, 1, 3'b100, 64'h100, 64'd0, 0, 64'd0, 0);
        chk("store_f3_2_code", {61'd0, cap_code}, 64'd2);

        // Further lane/extension patterns
        txn(0, 1, 3'b001, 64'h10A, 64'h000000000000BEEF, 0, 64'd0, 0);
        chk("sh_be", {56'd0, cap_be}, 64'h0C);
        txn(1, 0, 3'b101, 64'h106, 64'd0, 2, 64'hABCD_0000_0000_0000, 0);
        chk("lhu_rdata", cap_rdata, 64'hABCD);
        txn(1, 0, 3'b110, 64'h104, 64'd0, 0, 64'h89ABCDEF_00000000, 0);
        chk("lwu_rdata", cap_rdata, 64'h89ABCDEF);
        txn(1, 0, 3'b010, 64'h104, 64'd0, 0, 64'h89ABCDEF_00000000, 0);
        chk("lw_rdata", cap_rdata, 64'hFFFFFFFF89ABCDEF);
        txn(1, 0, 3'b011, 64'h0FC, 64'd0, 0, 64'h0123456789ABCDEF, 0);

        // Reset in the second ACCESS cycle abandons the access
        req_cnt = 0; resp_cnt = 0;
        req_valid = 1; req_read = 1; req_funct3 = 3'b011; req_addr = 64'h300; req_wdata = 0;
        step();
        req_valid = 0; req_read = 0;
        exp_ready = 0; exp_req = 1; exp_addr = 64'h300; exp_be = 8'hFF; exp_we = 0; exp_wdata = 0;
        step();
        rst_n = 0;
        step();
        exp_ready = 1; exp_req = 0;
        rst_n = 1;
        dmem_ack = 1;
        step();
        dmem_ack = 0;
        repeat (3) step();
        chk("reset_no_resp", 64'(resp_cnt), 64'd0);

        // XLEN=32: LD and LWU are illegal
        v32 = 1; rd32 = 1; f3_32 = 3'b011; a32 = 32'h100;
        step();
        v32 = 0;
        chk("x32_ld_valid", {63'd0, rv32}, 64'd1);
        chk("x32_ld_code", {61'd0, code32}, 64'd2);
        chk("x32_ld_dreq", {63'd0, dreq32}, 64'd0);
        step();
        chk("x32_ready_back", {63'd0, rdy32}, 64'd1);
        v32 = 1; f3_32 = 3'b110;
        step();
        v32 = 0;
        chk("x32_lwu_code", {61'd0, code32}, 64'd2);
        step();

        run_chk = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
